// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// Covers the FSM states, requester IDs and the tie-break helper.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_winner(input logic i_req, input logic d_req,
                                       input logic last_grant);
    if (i_req && d_req) begin
      return (last_grant == REQ_I) ? REQ_D : REQ_I;
    end
    return d_req ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle of the icache, dcache and main-memory handshake signals.
// The master view belongs to the arbiter; the slave view to caches and memory.
interface memory_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/memory_port_arbiter.sv
// Shares the single main-memory block port between icache and dcache.
// One transfer at a time; a DONE cycle always separates consecutive grants.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_port_arbiter_if.master bus
);

  arb_state_t        state;
  logic              last_grant;
  logic              seen_busy;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic winner;
  logic done;

  assign i_req  = bus.i_read;
  assign d_req  = bus.d_read | bus.d_write;
  assign winner = pick_winner(i_req, d_req, last_grant);
  // Memory must have been seen busy before a low busywait counts as completion.
  assign done   = seen_busy && !bus.mem_busywait;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= REQ_I;
      seen_busy   <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            seen_busy <= 1'b0;
            if (winner == REQ_D) begin
              state       <= BUSY_D;
              address_q   <= bus.d_address;
              writedata_q <= bus.d_writedata;
              write_q     <= bus.d_write;
              read_q      <= !bus.d_write;
            end else begin
              state     <= BUSY_I;
              address_q <= bus.i_address;
              write_q   <= 1'b0;
              read_q    <= 1'b1;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_busywait) begin
            seen_busy <= 1'b1;
          end
          if (done) begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            seen_busy <= 1'b0;
            if (state == BUSY_I) begin
              i_rdata_q  <= bus.mem_readdata;
              last_grant <= REQ_I;
              state      <= DONE_I;
            end else begin
              if (read_q) begin
                d_rdata_q <= bus.mem_readdata;
              end
              last_grant <= REQ_D;
              state      <= DONE_D;
            end
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read      = read_q;
  assign bus.mem_write     = write_q;
  assign bus.mem_address   = address_q;
  assign bus.mem_writedata = writedata_q;
  assign bus.i_readdata    = i_rdata_q;
  assign bus.d_readdata    = d_rdata_q;
  assign bus.i_busywait    = i_req && (state != DONE_I);
  assign bus.d_busywait    = d_req && (state != DONE_D);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench: directed and randomized rounds against a
// transaction-level model of grant order, latency and returned data.
module tb_memory_port_arbiter;
  import mem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_port_arbiter_if bus ();

  memory_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: busywait stays low for lo_cfg cycles, then high for lat_cfg cycles.
  int lat_cfg = 1;
  int lo_cfg  = 0;
  int xfer_cnt = 0;
  logic [31:0] mem_array [64];
  logic [31:0] ref_mem   [64];

  always @(posedge clock) begin
    if (!(bus.mem_read || bus.mem_write)) xfer_cnt <= 0;
    else xfer_cnt <= xfer_cnt + 1;
  end

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) &&
                            (xfer_cnt >= lo_cfg) && (xfer_cnt < lo_cfg + lat_cfg);
  assign bus.mem_readdata = mem_array[bus.mem_address];

  logic        last_served;
  logic [31:0] exp_i_rd;
  logic [31:0] exp_d_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // One round: up to one request per cache, asserted together at a negedge.
  task automatic run_round(input string name, input bit i_en, input bit d_en, input bit d_wr,
                           input logic [5:0] ia, input logic [5:0] da, input logic [31:0] wd,
                           input int lat, input int lo);
    bit          first_d;
    bit          is_d;
    int          t;
    int          n_xfer;
    int          c_first;
    int          c_second;
    int          c_i;
    int          c_d;
    int          last_s;
    logic [31:0] new_i;
    logic [31:0] new_d;
    logic [5:0]  pend_a;
    logic [31:0] pend_w;
    bit          pend_v;

    lat_cfg  = lat;
    lo_cfg   = lo;
    t        = lat + lo + 1;
    n_xfer   = (i_en && d_en) ? 2 : 1;
    first_d  = (i_en && d_en) ? (last_served == REQ_I) : d_en;
    c_first  = t + 1;
    c_second = c_first + t + 2;
    c_i      = 0;
    c_d      = 0;
    new_i    = exp_i_rd;
    new_d    = exp_d_rd;
    pend_a   = '0;
    pend_w   = '0;
    pend_v   = 1'b0;
    is_d     = first_d;

    for (int k = 0; k < n_xfer; k++) begin
      is_d = (k == 0) ? first_d : !first_d;
      if (is_d) begin
        if (d_wr) ref_mem[da] = wd;
        else new_d = ref_mem[da];
        c_d = (k == 0) ? c_first : c_second;
      end else begin
        new_i = ref_mem[ia];
        c_i = (k == 0) ? c_first : c_second;
      end
    end
    last_served = is_d ? REQ_D : REQ_I;
    last_s = (n_xfer == 2) ? c_second : c_first;

    bus.i_read      = i_en;
    bus.i_address   = ia;
    bus.d_read      = d_en && !d_wr;
    bus.d_write     = d_en && d_wr;
    bus.d_address   = da;
    bus.d_writedata = wd;

    for (int s = 1; s <= last_s + 1; s++) begin
      bit act;
      bit act_d;
      bit exp_rd;
      bit exp_wr;
      tick();
      act   = 1'b0;
      act_d = 1'b0;
      if (s >= 1 && s <= t) begin
        act   = 1'b1;
        act_d = first_d;
      end else if (n_xfer == 2 && s >= c_first + 2 && s <= c_first + 1 + t) begin
        act   = 1'b1;
        act_d = !first_d;
      end
      exp_rd = act && !(act_d && d_wr);
      exp_wr = act && act_d && d_wr;
      check({name, ".mem_read"},  32'(bus.mem_read),  32'(exp_rd));
      check({name, ".mem_write"}, 32'(bus.mem_write), 32'(exp_wr));
      if (act) begin
        check({name, ".mem_address"}, 32'(bus.mem_address), 32'(act_d ? da : ia));
        if (exp_wr) begin
          check({name, ".mem_writedata"}, bus.mem_writedata, wd);
          pend_a = bus.mem_address;
          pend_w = bus.mem_writedata;
          pend_v = 1'b1;
        end
      end
      check({name, ".i_busywait"}, 32'(bus.i_busywait), 32'(i_en && s < c_i));
      check({name, ".d_busywait"}, 32'(bus.d_busywait), 32'(d_en && s < c_d));
      check({name, ".i_readdata"}, bus.i_readdata, (i_en && s >= c_i) ? new_i : exp_i_rd);
      check({name, ".d_readdata"}, bus.d_readdata,
            (d_en && !d_wr && s >= c_d) ? new_d : exp_d_rd);
      if (i_en && s == c_i) bus.i_read = 1'b0;
      if (d_en && s == c_d) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        if (pend_v) mem_array[pend_a] = pend_w;
      end
    end
    exp_i_rd = new_i;
    exp_d_rd = new_d;
  endtask

  task automatic applyStimulus();
    int pat;
    reset           = 1'b0;
    bus.i_read      = 1'b0;
    bus.i_address   = '0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_address   = '0;
    bus.d_writedata = '0;
    for (int i = 0; i < 64; i++) mem_array[i] = $urandom;
    mem_array[5] = 32'hDEADBEEF;
    ref_mem      = mem_array;
    last_served  = REQ_I;
    exp_i_rd     = '0;
    exp_d_rd     = '0;

    repeat (3) tick();
    check("reset.mem_read",    32'(bus.mem_read),  32'd0);
    check("reset.mem_write",   32'(bus.mem_write), 32'd0);
    check("reset.mem_address", 32'(bus.mem_address), 32'd0);
    check("reset.i_readdata",  bus.i_readdata, 32'd0);
    check("reset.d_readdata",  bus.d_readdata, 32'd0);
    reset = 1'b1;
    tick();

    run_round("tie", 1, 1, 0, 6'h01, 6'h02, 32'd0, 4, 0);
    run_round("lone_i", 1, 0, 0, 6'h05, 6'h00, 32'd0, 5, 0);
    for (int r = 0; r < 4; r++) begin
      run_round("tie_rr", 1, 1, 1'($urandom_range(0, 1)), 6'(6'h10 + r), 6'(6'h20 + r),
                $urandom, $urandom_range(1, 4), 0);
    end
    run_round("wb", 0, 1, 1, 6'h00, 6'h3F, 32'h12345678, 3, 0);
    run_round("late_busy", 1, 0, 0, 6'h07, 6'h00, 32'd0, 3, 2);

    for (int r = 0; r < 20; r++) begin
      pat = $urandom_range(1, 3);
      run_round("rand", pat[0], pat[1], 1'($urandom_range(0, 1)), 6'($urandom),
                6'($urandom), $urandom, $urandom_range(1, 6), $urandom_range(0, 2));
    end

    // Reset lands in the third BUSY_D cycle of a dcache read.
    lat_cfg       = 6;
    lo_cfg        = 0;
    bus.d_read    = 1'b1;
    bus.d_address = 6'h0A;
    tick();
    tick();
    tick();
    check("rst_mid.mem_read_before", 32'(bus.mem_read), 32'd1);
    reset      = 1'b0;
    bus.d_read = 1'b0;
    tick();
    check("rst_mid.mem_read",    32'(bus.mem_read),    32'd0);
    check("rst_mid.mem_write",   32'(bus.mem_write),   32'd0);
    check("rst_mid.mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mid.i_readdata",  bus.i_readdata, 32'd0);
    check("rst_mid.d_readdata",  bus.d_readdata, 32'd0);
    reset       = 1'b1;
    last_served = REQ_I;
    exp_i_rd    = '0;
    exp_d_rd    = '0;
    tick();
    run_round("after_rst", 1, 0, 0, 6'h01, 6'h00, 32'd0, 3, 0);
    run_round("after_rst_tie", 1, 1, 0, 6'h03, 6'h04, 32'd0, 2, 1);
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single main-memory block port between the instruction cache and the data cache. Each cache issues block reads (data cache also block write-backs) with its existing read/write/busywait handshake; the arbiter grants one requester at a time, forwards the transfer to memory, and returns the block and a completion.

## Interface
Parameters:
- ADDR_W, 6: block address width (memory port address).
- DATA_W, 32: block data width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset is synchronous, active-low.
- i_read  in  1  icache block-read request (icache never writes).
- i_address  in  ADDR_W  icache block address.
- i_readdata  out  DATA_W  block returned to icache.
- i_busywait  out  1  icache stall.
- d_read  in  1  dcache block-read request.
- d_write  in  1  dcache write-back request.
- d_address  in  ADDR_W  dcache block address.
- d_writedata  in  DATA_W  dcache write-back block.
- d_readdata  out  DATA_W  block returned to dcache.
- d_busywait  out  1  dcache stall.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  latched block address.
- mem_writedata  out  DATA_W  latched write-back block.
- mem_readdata  in  DATA_W  block from memory.
- mem_busywait  in  1  memory busy.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: on a posedge with a pending request, latch the winner's address (and d_writedata/op for the dcache) and move to BUSY_I/BUSY_D. d_read and d_write both high is illegal; treat it as write.
- Tie (i_read and d request at the same edge): grant the requester not served last. last_grant resets to I, so the first tie goes to D.
- BUSY_x: mem_read/mem_write held high with latched address/data. A seen_busy flag sets on the first sampled mem_busywait=1. Completion is a posedge in BUSY_x with seen_busy=1 and mem_busywait=0. On completion: capture mem_readdata into x_readdata (reads only), clear the strobes, go to DONE_x, update last_grant=x.
- DONE_x: one cycle, then IDLE. The requester must drop its request by the end of this cycle; a request still high in IDLE is a new request.
- x_busywait (combinational) = x request high and state != DONE_x. The non-granted requester stays stalled.
- A requester that drops its request mid-BUSY does not abort the memory transfer. The arbiter completes it, still updates x_readdata, then goes through DONE_x.
- x_readdata holds its last value between transfers.

## Timing
- Reset (low at a posedge): state=IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, i_readdata=d_readdata=0, seen_busy=0, last_grant=I. This also applies mid-transfer; the memory transaction is abandoned.
- Request sampled at edge k: strobe visible after edge k. Completion at edge m gives readdata valid and busywait low after edge m. The arbiter adds 2 cycles over raw memory latency (grant edge plus DONE cycle).
- Strobes and mem_address are registered outputs and never glitch. busywait outputs are combinational.
- No back-to-back grant: at least one IDLE cycle separates transfers.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D), requester ID constants REQ_I=0/REQ_D=1, default ADDR_W/DATA_W.
- Single module, about 150–200 lines. No sub-module is warranted; the tie-break is one flop plus a mux.

## Test plan
- Lone icache read: i_address=6'h05, memory busy 5 cycles, returns 32'hDEADBEEF. Required: mem_read high 6 cycles, i_readdata=32'hDEADBEEF, i_busywait low for exactly 1 cycle, d_busywait unaffected.
- Simultaneous i_read (6'h01) and d_read (6'h02) after reset. Required: D served first with mem_address=6'h02 while i_busywait stays high; then I served with 6'h01.
- Repeated ties over 4 rounds. Required: grants alternate D, I, D, I.
- dcache write-back: d_write, 6'h3F, 32'h12345678. Required: mem_write=1, mem_writedata=32'h12345678, d_readdata unchanged.
- reset=0 in the third BUSY_D cycle. Required: after that edge, strobes low, state IDLE, readdata=0. A subsequent i_read completes normally.
- Memory that holds mem_busywait low for 2 cycles before raising it. Required: no premature completion; the transfer completes only after the busy high-to-low transition.
